mem_arb: RTL
============

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32: data width, equal to the width of the attached memory.
REQ-002 The block SHALL take parameter DEPTH, default 512: memory depth; AW = $clog2(DEPTH).
REQ-003 The block SHALL take parameter NW, default 2: number of write requesters.
REQ-004 The block SHALL take parameter NR, default 4: number of read requesters.
REQ-005 The block SHALL provide port clk, input, 1 bit: the single clock, feeding both memory ports.
REQ-006 The block SHALL provide port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL provide port wr_req, input, NW bits: per-requester write request.
REQ-008 The block SHALL provide port wr_addr, input, NW*AW bits: flattened write addresses, requester i at [i*AW +: AW].
REQ-009 The block SHALL provide port wr_data, input, NW*WIDTH bits: flattened write data.
REQ-010 The block SHALL provide port wr_gnt, output, NW bits: one-hot write grant, combinational.
REQ-011 The block SHALL provide port rd_req, input, NR bits: per-requester read request.
REQ-012 The block SHALL provide port rd_addr, input, NR*AW bits: flattened read addresses.
REQ-013 The block SHALL provide port rd_gnt, output, NR bits: one-hot read grant, combinational.
REQ-014 The block SHALL provide port rd_valid, output, NR bits: one-hot, registered; marks read data return.
REQ-015 The block SHALL provide port rd_data, output, WIDTH bits: read data, valid with rd_valid.
REQ-016 The block SHALL provide memory-side outputs mem_enA (1), mem_weA (1), mem_addrA (AW), mem_dinA (WIDTH), mem_enB (1) and mem_addrB (AW).
REQ-017 The block SHALL provide port mem_doutB, input, WIDTH bits: memory read data, one cycle after mem_enB.

Function
REQ-018 Write arbitration SHALL be round-robin over wr_req: the search starts at wr_ptr and wraps modulo NW; at most one wr_gnt bit is set, and only for a requesting index.
REQ-019 While any wr_gnt bit is set, the block SHALL drive mem_enA=1 and mem_weA=1, with mem_addrA and mem_dinA taken from the granted requester; otherwise mem_enA=0 and mem_weA=0.
REQ-020 A granted write SHALL complete in its grant cycle; a requester holds wr_req, wr_addr and wr_data stable until it sees wr_gnt.
REQ-021 On each cycle with a write grant to index g, wr_ptr SHALL update to (g+1) mod NW; with no grant, wr_ptr SHALL hold.
REQ-022 Read arbitration SHALL be round-robin over the eligible rd_req with its own pointer rd_ptr, using the same rules as REQ-018 and REQ-021.
REQ-023 A read request SHALL be ineligible in any cycle where a write is granted to an identical address; that request receives no grant that cycle and is retried, so read-during-write to one address never returns stale data.
REQ-024 While any rd_gnt bit is set, the block SHALL drive mem_enB=1, with mem_addrB taken from the granted requester; otherwise mem_enB=0.
REQ-025 On a read grant to index g, exactly one cycle later the block SHALL assert rd_valid[g]=1 and drive rd_data=mem_doutB; read latency is one cycle from grant.
REQ-026 rd_valid SHALL be 0 in any cycle following a cycle with no read grant.
REQ-027 rd_data SHALL pass through combinationally from mem_doutB; its value is defined only while rd_valid is non-zero.
REQ-028 Requesters SHALL accept rd_valid unconditionally; there is no backpressure.
REQ-029 Back-to-back reads SHALL sustain one grant per cycle.
REQ-030 A single requester holding rd_req SHALL be granted every cycle when no other requester competes.
REQ-031 Reads and writes SHALL be arbitrated independently and may both be granted in the same cycle when their addresses differ.
REQ-032 With NW=1 or NR=1, the corresponding pointer SHALL be constant 0 and the grant SHALL equal the request.

Reset
REQ-033 rst_n low SHALL asynchronously clear wr_ptr, rd_ptr and the registered rd_valid to 0.
REQ-034 While rst_n is low, all grants and mem_enA, mem_weA and mem_enB SHALL be 0.
REQ-035 After rst_n deasserts, arbitration SHALL resume at the first rising clk edge.
REQ-036 A read granted in the cycle in which reset asserts SHALL return no rd_valid.

Structure
REQ-037 The shared package SHALL hold the default WIDTH, DEPTH, NW and NR constants and the AW derivation function.
REQ-038 A sub-module rr_arb (parameter N: inputs req and ptr; outputs one-hot gnt and next_ptr) SHALL be instantiated twice, once for writes and once for reads.
REQ-039 The memory itself SHALL remain outside this block.

Verification
REQ-040 Bench SHALL cover: wr_req=2'b11 held for 4 cycles -> wr_gnt sequence 01,10,01,10, and mem_weA=1 on each cycle.
REQ-041 Bench SHALL cover: rd_req=4'b1111 held -> rd_gnt sequence 0001,0010,0100,1000,0001, with rd_valid equal to the same sequence delayed by one cycle.
REQ-042 Bench SHALL cover: write 0xDEADBEEF to address 5 while a read of address 5 is requested the same cycle -> read ungranted that cycle, granted the next, rd_data=0xDEADBEEF.
REQ-043 Bench SHALL cover: a write to address 3 and a read of address 7 in the same cycle -> both granted, and the read returns the prior contents of address 7.
REQ-044 Bench SHALL cover: rst_n pulsed low mid-burst with a read granted -> rd_valid=0 immediately, and after release wr_gnt and rd_gnt restart from index 0.
REQ-045 Bench SHALL cover: no requests for 10 cycles -> mem_enA, mem_enB, all grants and rd_valid remain 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared defaults and width helpers for the memory arbiter.
package mem_arb_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 512;
  localparam int DEF_NW    = 2;
  localparam int DEF_NR    = 4;

  // Address width for a memory of the given depth; never narrower than one bit.
  function automatic int aw_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Pointer width for an n-way arbiter; a single requester still gets one bit.
  function automatic int pw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arb
  import mem_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = pw_of(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);

  int idx;
  logic found;

  // Scan from ptr modulo N; first hit wins and next search starts just past it.
  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        next_ptr = PW'((idx + 1) % N);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates NW writers onto memory port A and NR readers onto port B of an
// external dual-port RAM; reads colliding with the granted write are deferred.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NW    = DEF_NW,
  parameter int NR    = DEF_NR,
  localparam int AW   = aw_of(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NW-1:0]       wr_req,
  input  logic [NW*AW-1:0]    wr_addr,
  input  logic [NW*WIDTH-1:0] wr_data,
  output logic [NW-1:0]       wr_gnt,
  input  logic [NR-1:0]       rd_req,
  input  logic [NR*AW-1:0]    rd_addr,
  output logic [NR-1:0]       rd_gnt,
  output logic [NR-1:0]       rd_valid,
  output logic [WIDTH-1:0]    rd_data,
  output logic                mem_enA,
  output logic                mem_weA,
  output logic [AW-1:0]       mem_addrA,
  output logic [WIDTH-1:0]    mem_dinA,
  output logic                mem_enB,
  output logic [AW-1:0]       mem_addrB,
  input  logic [WIDTH-1:0]    mem_doutB
);

  localparam int WPW = pw_of(NW);
  localparam int RPW = pw_of(NR);

  logic [WPW-1:0] wr_ptr, wr_ptr_nxt;
  logic [RPW-1:0] rd_ptr, rd_ptr_nxt;
  logic [NW-1:0]  wr_gnt_raw;
  logic [NR-1:0]  rd_gnt_raw;
  logic [NR-1:0]  rd_elig;
  logic [NR-1:0]  vld_p1;
  logic           wr_any;

  rr_arb #(.N(NW)) u_wr_arb (
    .req      (wr_req),
    .ptr      (wr_ptr),
    .gnt      (wr_gnt_raw),
    .next_ptr (wr_ptr_nxt)
  );

  rr_arb #(.N(NR)) u_rd_arb (
    .req      (rd_elig),
    .ptr      (rd_ptr),
    .gnt      (rd_gnt_raw),
    .next_ptr (rd_ptr_nxt)
  );

  // Grants are forced low while reset is held so the memory sees no strobes.
  assign wr_gnt  = rst_n ? wr_gnt_raw : '0;
  assign rd_gnt  = rst_n ? rd_gnt_raw : '0;
  assign wr_any  = |wr_gnt;
  assign mem_enA = wr_any;
  assign mem_weA = wr_any;
  assign mem_enB = |rd_gnt;

  // Steer the granted writer's address and data onto port A.
  always_comb begin
    mem_addrA = '0;
    mem_dinA  = '0;
    for (int i = 0; i < NW; i++) begin
      if (wr_gnt[i]) begin
        mem_addrA = wr_addr[i*AW +: AW];
        mem_dinA  = wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // A read aimed at the address being written this cycle sits out and retries.
  always_comb begin
    rd_elig = rd_req;
    for (int i = 0; i < NR; i++) begin
      if (wr_any && (rd_addr[i*AW +: AW] == mem_addrA)) rd_elig[i] = 1'b0;
    end
  end

  // Steer the granted reader's address onto port B.
  always_comb begin
    mem_addrB = '0;
    for (int i = 0; i < NR; i++) begin
      if (rd_gnt[i]) mem_addrB = rd_addr[i*AW +: AW];
    end
  end

  // Pointers advance past the winner; with no grant they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_any)  wr_ptr <= wr_ptr_nxt;
      if (mem_enB) rd_ptr <= rd_ptr_nxt;
    end
  end

  // grant cycle -> data-return cycle: valid follows the grant by one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= '0;
    else        vld_p1 <= rd_gnt;
  end

  assign rd_valid = vld_p1;
  assign rd_data  = mem_doutB;

endmodule
